// File: rtl/mem_pkg.sv
// Shared definitions for the memory round-robin arbiter: Avalon width
// defaults and the arbiter state encoding (also exported as arb_owner).
package mem_pkg;

  localparam int unsigned AV_ADDR_WIDTH = 20;
  localparam int unsigned AV_DATA_WIDTH = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_STIM  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_CHECK = 2'd3
  } arb_state_e;

endpackage

// File: rtl/mem_rr_arb.sv
// Two-master arbiter in front of sram_arb: the stim side issues reads, the
// check side issues writes; grants alternate after MAX_GRANT accepted beats.
module mem_rr_arb
  import mem_pkg::*;
#(
  parameter int ADDR_WIDTH = AV_ADDR_WIDTH,
  parameter int DATA_WIDTH = AV_DATA_WIDTH,
  parameter int BE_WIDTH   = DATA_WIDTH / 8,
  parameter int MAX_GRANT  = 4,
  parameter int MAX_PEND   = 4
) (
  input  logic                  clock,
  input  logic                  reset_n,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [BE_WIDTH-1:0]   mem_byteenable,
  output logic                  mem_read,
  input  logic [DATA_WIDTH-1:0] mem_readdata,
  input  logic                  mem_readdataready,
  output logic                  mem_write,
  output logic [DATA_WIDTH-1:0] mem_writedata,
  input  logic                  mem_waitrequest,
  input  logic [ADDR_WIDTH-1:0] stim_address,
  input  logic [BE_WIDTH-1:0]   stim_byteenable,
  input  logic                  stim_read,
  output logic [DATA_WIDTH-1:0] stim_readdata,
  output logic                  stim_readdataready,
  output logic                  stim_waitrequest,
  input  logic [ADDR_WIDTH-1:0] check_address,
  input  logic [BE_WIDTH-1:0]   check_byteenable,
  input  logic                  check_write,
  input  logic [DATA_WIDTH-1:0] check_writedata,
  output logic                  check_waitrequest,
  output logic [1:0]            arb_owner
);

  localparam int PW = $clog2(MAX_PEND + 1);
  localparam int BW = (MAX_GRANT > 1) ? $clog2(MAX_GRANT) : 1;
  localparam logic [PW-1:0] PEND_MAX   = PW'(MAX_PEND);
  localparam logic [BW-1:0] GRANT_LAST = BW'(MAX_GRANT - 1);

  arb_state_e      state_q, state_d;
  logic [BW-1:0]   burst_q, burst_d;
  logic [PW-1:0]   pend_q, pend_d;
  logic            rd_acc, wr_acc, acc, rd_ret, quota;

  assign mem_read  = (state_q == ST_STIM) && stim_read && (pend_q < PEND_MAX);
  assign mem_write = (state_q == ST_CHECK) && check_write;

  assign mem_address    = (state_q == ST_STIM) ? stim_address    : check_address;
  assign mem_byteenable = (state_q == ST_STIM) ? stim_byteenable : check_byteenable;
  assign mem_writedata  = check_writedata;

  assign stim_waitrequest  = (state_q != ST_STIM) || mem_waitrequest || (pend_q == PEND_MAX);
  assign check_waitrequest = (state_q != ST_CHECK) || mem_waitrequest;

  assign stim_readdata      = mem_readdata;
  assign stim_readdataready = mem_readdataready;
  assign arb_owner          = state_q;

  assign rd_acc = mem_read && !mem_waitrequest;
  assign wr_acc = mem_write && !mem_waitrequest;
  assign acc    = rd_acc || wr_acc;
  // A return with nothing outstanding is a stray pulse and is not counted.
  assign rd_ret = mem_readdataready && (pend_q != '0);
  assign quota  = acc && (burst_q == GRANT_LAST);

  always_comb begin
    pend_d = pend_q;
    if (rd_acc && !rd_ret)      pend_d = pend_q + 1'b1;
    else if (!rd_acc && rd_ret) pend_d = pend_q - 1'b1;
  end

  // CHECK is only entered with no reads in flight, so a write can never
  // overtake an outstanding read; otherwise the path goes through DRAIN.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (stim_read)        state_d = ST_STIM;
        else if (check_write) state_d = (pend_q == '0) ? ST_CHECK : ST_DRAIN;
      end
      ST_STIM: begin
        if (!stim_read) begin
          if (check_write) state_d = (pend_q == '0) ? ST_CHECK : ST_DRAIN;
          else             state_d = ST_IDLE;
        end else if (quota && check_write) begin
          state_d = (pend_d == '0) ? ST_CHECK : ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (pend_q == '0) state_d = ST_CHECK;
      end
      ST_CHECK: begin
        if (!check_write)           state_d = stim_read ? ST_STIM : ST_IDLE;
        else if (quota && stim_read) state_d = ST_STIM;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    burst_d = burst_q;
    if (state_d != state_q)              burst_d = '0;
    else if (acc && burst_q != GRANT_LAST) burst_d = burst_q + 1'b1;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      burst_q <= '0;
      pend_q  <= '0;
    end else begin
      state_q <= state_d;
      burst_q <= burst_d;
      pend_q  <= pend_d;
    end
  end

endmodule

// File: doc/mem_rr_arb.md
MEM_RR_ARB -- requirements
Module: mem_rr_arb

Interface
REQ-001 SHALL have parameters: ADDR_WIDTH, default 20, address bits; DATA_WIDTH, default 16, data bits; BE_WIDTH, default DATA_WIDTH/8, byte-enable bits; MAX_GRANT, default 4, max consecutive accepted transfers per owner while the other side waits; MAX_PEND, default 4, max outstanding reads.
REQ-002 SHALL have ports (name direction width meaning):
  clock  in  1  single clock, all state on rising edge
  reset_n  in  1  asynchronous, active-low reset
  mem_address  out  ADDR_WIDTH  to sram_arb
  mem_byteenable  out  BE_WIDTH  to sram_arb
  mem_read  out  1  read command
  mem_readdata  in  DATA_WIDTH  read data
  mem_readdataready  in  1  read data valid
  mem_write  out  1  write command
  mem_writedata  out  DATA_WIDTH  write data
  mem_waitrequest  in  1  sram_arb stall
  stim_address  in  ADDR_WIDTH; stim_byteenable  in  BE_WIDTH; stim_read  in  1
  stim_readdata  out  DATA_WIDTH; stim_readdataready  out  1; stim_waitrequest  out  1
  check_address  in  ADDR_WIDTH; check_byteenable  in  BE_WIDTH; check_write  in  1
  check_writedata  in  DATA_WIDTH; check_waitrequest  out  1
  arb_owner  out  2  current state encoding, for debug

Function
REQ-003 SHALL implement registered FSM: IDLE, STIM, DRAIN, CHECK.
REQ-004 IDLE: stim_read -> STIM; else check_write -> CHECK; else stay; stim_read wins when both high.
REQ-005 STIM: on stim_read low -> CHECK if check_write and pend_cnt==0, DRAIN if check_write and pend_cnt!=0, else IDLE.
REQ-006 STIM: on accepted read with burst_cnt==MAX_GRANT-1 and check_write high -> DRAIN (or CHECK if pend_cnt becomes 0 that cycle).
REQ-007 DRAIN: issues nothing; -> CHECK when pend_cnt==0.
REQ-008 CHECK: on check_write low -> STIM if stim_read else IDLE; on accepted write with burst_cnt==MAX_GRANT-1 and stim_read high -> STIM.
REQ-009 Accepted transfer = (mem_read or mem_write) and not mem_waitrequest.
REQ-010 burst_cnt SHALL clear on every state change and increment on each accepted transfer, saturating at MAX_GRANT-1.
REQ-011 mem_read = (state==STIM) and stim_read and (pend_cnt<MAX_PEND); mem_write = (state==CHECK) and check_write; both never high together.
REQ-012 mem_address/mem_byteenable SHALL come from stim in STIM, from check otherwise; mem_writedata = check_writedata.
REQ-013 stim_waitrequest = not(state==STIM) or mem_waitrequest or pend_cnt==MAX_PEND; check_waitrequest = not(state==CHECK) or mem_waitrequest.
REQ-014 Request first seen in IDLE SHALL be stalled that cycle; command reaches mem_* the next cycle (one-cycle grant latency).
REQ-015 pend_cnt, width clog2(MAX_PEND+1): +1 on accepted read, -1 on mem_readdataready, unchanged when both same cycle; never below 0 (readdataready at 0 ignored).
REQ-016 stim_readdata = mem_readdata, stim_readdataready = mem_readdataready, combinational passthrough in every state.
REQ-017 No write SHALL be issued while pend_cnt!=0 (read/write ordering to SRAM).

Reset
REQ-018 On reset_n low, asynchronously: state=IDLE, burst_cnt=0, pend_cnt=0; hence mem_read=0, mem_write=0, stim_waitrequest=1, check_waitrequest=1, arb_owner=IDLE.
REQ-019 Read data arriving after mid-operation reset SHALL still pass through; pend_cnt stays 0.

Structure
REQ-020 FSM state encoding (IDLE=0, STIM=1, DRAIN=2, CHECK=3) SHALL live in shared package mem_pkg, with Avalon width defaults.
REQ-021 Single flat module; no sub-module required.

Verification
REQ-022 Both request from IDLE, waitrequest low -> cycle 1 both stalled, then 4 stim reads accepted, DRAIN until 4 readdataready, then check write accepted.
REQ-023 stim reads with readdataready held low, MAX_PEND=4 -> 4 accepts, 5th: mem_read=0, stim_waitrequest=1 until one readdataready.
REQ-024 Accepted read and readdataready same cycle at pend_cnt=2 -> pend_cnt stays 2.
REQ-025 check_write only, mem_waitrequest high 3 cycles -> mem_write held, address/data stable, accepted cycle 4, burst_cnt=1.
REQ-026 reset_n pulsed low mid-CHECK with pend_cnt=0 -> same cycle mem_write=0, both waitrequests=1, arb_owner=0.
REQ-027 Spurious readdataready at pend_cnt=0 -> pend_cnt stays 0, stim_readdataready=1 passed through.
